// File: rtl/fifo_rd_ctrl.sv
`timescale 1ns/1ps
// fifo_rd_ctrl: read-side controller of the dual-clock FIFO.
//
// The block owns the read pointer (binary and Gray) and drives the storage
// read address. It produces a registered empty flag and a sticky underflow
// flag. It also brings the write domain's Gray pointer into r_clk through a
// plain flop chain.
//
// Parameters:
//   ADDR_WIDTH   storage address width; depth = 2**ADDR_WIDTH, pointers are
//                ADDR_WIDTH+1 bits wide (the extra bit is the wrap bit)
//   SYNC_STAGES  write-pointer synchronizer depth, 2 or 3
//
// Ports:
//   r_clk        read clock, rising edge
//   r_rst        asynchronous active-high reset
//   r_inc        read request; pops when r_empty is low
//   wptr_gray    Gray write pointer from the write domain (asynchronous)
//   rd_addr      storage read address (low bits of the binary read pointer)
//   rptr_gray    registered Gray read pointer, sent to the write domain
//   r_empty      registered empty flag
//   r_underflow  sticky flag, set by a read request while empty
//   r_level      (FIFO_RD_LEVEL_EN only) registered occupancy seen from r_clk
//
// Optional feature macro: FIFO_RD_LEVEL_EN adds the r_level output.

module fifo_rd_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  r_inc,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  r_empty,
`ifdef FIFO_RD_LEVEL_EN
    output logic [ADDR_WIDTH:0]   r_level,
`endif
    output logic                  r_underflow
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wq_wptr;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic          pop;

    // Write-pointer synchronizer: a bare flop chain with nothing between stages.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wptr_gray;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_wptr = sync_q[SYNC_STAGES-1];

    // Next-pointer logic; a request while empty leaves the pointers unchanged.
    always_comb begin
        pop        = r_inc & ~r_empty;
        rbin_next  = rptr_bin + PW'(pop);
        rgray_next = rbin_next ^ (rbin_next >> 1);
    end

    // Pointer, empty and underflow registers. Empty looks ahead at rgray_next
    // so the flag is correct on the cycle right after the last pop.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            rptr_bin    <= '0;
            rptr_gray   <= '0;
            r_empty     <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            rptr_bin    <= rbin_next;
            rptr_gray   <= rgray_next;
            r_empty     <= (rgray_next == wq_wptr);
            r_underflow <= r_underflow | (r_inc & r_empty);
        end
    end

    assign rd_addr = rptr_bin[ADDR_WIDTH-1:0];

`ifdef FIFO_RD_LEVEL_EN
    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Occupancy from the synchronized write pointer; zero exactly when empty.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            r_level <= '0;
        end else begin
            r_level <= gray2bin(wq_wptr) - rbin_next;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
`timescale 1ns/1ps
// tb_fifo_rd_ctrl: directed self-checking bench for fifo_rd_ctrl with the
// default parameters (ADDR_WIDTH=3, SYNC_STAGES=2). Inputs change and outputs
// are sampled on the falling edge of r_clk.

module tb_fifo_rd_ctrl;

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic       r_inc;
    logic [3:0] wptr_gray;
    logic [2:0] rd_addr;
    logic [3:0] rptr_gray;
    logic       r_empty;
    logic       r_underflow;
`ifdef FIFO_RD_LEVEL_EN
    logic [3:0] r_level;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Expected Gray read pointer after pops 1..8 and 9..16.
    logic [3:0] gray_lo [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100};
    logic [3:0] gray_hi [8] = '{4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                4'b1011, 4'b1001, 4'b1000, 4'b0000};

    fifo_rd_ctrl #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2)
    ) dut (
        .r_clk       (r_clk),
        .r_rst       (r_rst),
        .r_inc       (r_inc),
        .wptr_gray   (wptr_gray),
        .rd_addr     (rd_addr),
        .rptr_gray   (rptr_gray),
        .r_empty     (r_empty),
`ifdef FIFO_RD_LEVEL_EN
        .r_level     (r_level),
`endif
        .r_underflow (r_underflow)
    );

    always #5 r_clk = ~r_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then back to the falling edge for sampling/driving.
    task automatic step();
        @(posedge r_clk);
        @(negedge r_clk);
    endtask

    // Reset asserted between edges must act at once, without a clock.
    task automatic mid_clock_reset(input string tag);
        @(negedge r_clk);
        #2;
        r_rst = 1'b1;
        #1;
        check_val({tag, "_empty"}, 32'(r_empty), 32'd1);
        check_val({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check_val({tag, "_rptr_gray"}, 32'(rptr_gray), 32'd0);
        check_val({tag, "_underflow"}, 32'(r_underflow), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
        check_val({tag, "_level"}, 32'(r_level), 32'd0);
`endif
        @(negedge r_clk);
        r_rst = 1'b0;
    endtask

    initial begin
        r_rst     = 1'b1;
        r_inc     = 1'b0;
        wptr_gray = 4'b0000;
        @(negedge r_clk);
        @(negedge r_clk);
        check_val("por_empty", 32'(r_empty), 32'd1);
        check_val("por_rd_addr", 32'(rd_addr), 32'd0);
        r_rst = 1'b0;

        // Write-to-empty latency: one write visible after the third edge.
        wptr_gray = 4'b0001;
        step();
        check_val("lat_edge1_empty", 32'(r_empty), 32'd1);
        step();
        check_val("lat_edge2_empty", 32'(r_empty), 32'd1);
        step();
        check_val("lat_edge3_empty", 32'(r_empty), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
        check_val("lat_level", 32'(r_level), 32'd1);
`endif
        check_val("lat_rptr_gray", 32'(rptr_gray), 32'd0);

        mid_clock_reset("rst1");

        // Drain eight entries.
        wptr_gray = 4'b1100;
        step(); step(); step();
        check_val("drain_ready_empty", 32'(r_empty), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
        check_val("drain_level", 32'(r_level), 32'd8);
`endif
        r_inc = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("drain_addr%0d", k), 32'(rd_addr), 32'(k));
            step();
            check_val($sformatf("drain_gray%0d", k), 32'(rptr_gray), 32'(gray_lo[k]));
            check_val($sformatf("drain_empty%0d", k), 32'(r_empty), (k == 7) ? 32'd1 : 32'd0);
        end
        r_inc = 1'b0;
        check_val("drain_underflow", 32'(r_underflow), 32'd0);

        // Eight more writes and pops: pointer wraps 1111 -> 0000.
        wptr_gray = 4'b0000;
        step(); step(); step();
        check_val("wrap_ready_empty", 32'(r_empty), 32'd0);
        r_inc = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("wrap_addr%0d", k), 32'(rd_addr), 32'(k));
            step();
            check_val($sformatf("wrap_gray%0d", k), 32'(rptr_gray), 32'(gray_hi[k]));
            check_val($sformatf("wrap_empty%0d", k), 32'(r_empty), (k == 7) ? 32'd1 : 32'd0);
        end
        check_val("wrap_addr_end", 32'(rd_addr), 32'd0);

        // Underflow: request while empty, pointers hold, flag sticks.
        step();
        check_val("uf_gray_hold", 32'(rptr_gray), 32'd0);
        check_val("uf_addr_hold", 32'(rd_addr), 32'd0);
        check_val("uf_empty", 32'(r_empty), 32'd1);
        check_val("uf_set", 32'(r_underflow), 32'd1);
        r_inc = 1'b0;
        step(); step(); step();
        check_val("uf_sticky", 32'(r_underflow), 32'd1);
        check_val("uf_gray_final", 32'(rptr_gray), 32'd0);

        mid_clock_reset("rst2");

        // Simultaneous: last entry popped in the cycle wq_wptr advances.
        wptr_gray = 4'b0001;
        step(); step(); step();
        check_val("sim_ready_empty", 32'(r_empty), 32'd0);
        wptr_gray = 4'b0011;
        step(); step();
        check_val("sim_pre_empty", 32'(r_empty), 32'd0);
        r_inc = 1'b1;
        step();
        check_val("sim_pop1_empty", 32'(r_empty), 32'd0);
        check_val("sim_pop1_addr", 32'(rd_addr), 32'd1);
        check_val("sim_pop1_gray", 32'(rptr_gray), 32'b0001);
`ifdef FIFO_RD_LEVEL_EN
        check_val("sim_pop1_level", 32'(r_level), 32'd1);
`endif
        step();
        check_val("sim_pop2_empty", 32'(r_empty), 32'd1);
        check_val("sim_pop2_addr", 32'(rd_addr), 32'd2);
        check_val("sim_pop2_gray", 32'(rptr_gray), 32'b0011);
        r_inc = 1'b0;
        step();
        check_val("sim_no_underflow", 32'(r_underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
